dot_product_pipe: RTL and testbench

- Parametrised, fully pipelined dot-product engine for the matrix multiplier.
- Holds a LANES-element X vector and a DEPTH-row by LANES-column W matrix, both loaded one element per cycle over a shared input_data bus.
- Each issued beat multiplies X by one W row lane-wise and reduces the products through a registered saturating adder tree.
- Beats are accumulated into a saturating accumulator, framed by first/last flags, and results are returned over a valid/ready output with backpressure.

---
 rtl/dot_product_pkg.sv | 42 ++++
 rtl/dot_product_pipe_tree.sv | 72 +++++++
 rtl/dot_product_pipe.sv | 129 ++++++++++++
 tb/tb_dot_product_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the dot-product pipeline: beat tags, tree depth
// and a width-generic saturating adder.
package dot_product_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic sat;
    } tag_t;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               ovf;
    } sat_res_t;

    function automatic int tree_depth(input int lanes);
        return $clog2(lanes);
    endfunction

    // Operands must already be sign-extended values within the w-bit range.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int w);
        logic signed [64:0] s, hi, lo;
        sat_res_t r;
        s = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        r.sum = s[63:0];
        r.ovf = 1'b0;
        if (s > hi) begin
            r.sum = hi[63:0];
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.sum = lo[63:0];
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_product_pipe_tree.sv
// Registered pairwise saturating reduction of LANES values; one stage per level,
// beat tag travels alongside and collects any clamp seen on its way to the root.
module sat_adder_tree
    import dot_product_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int ACC_WIDTH = 28
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_stall,
    input  tag_t                              i_tag,
    input  logic [LANES-1:0][ACC_WIDTH-1:0]   i_data,
    output tag_t                              o_tag,
    output logic signed [ACC_WIDTH-1:0]       o_sum
);
    localparam int T = tree_depth(LANES);

    // Heap numbering: node i has children 2i and 2i+1, leaves are LANES..2*LANES-1.
    logic signed [ACC_WIDTH-1:0] w_node    [1:2*LANES-1];
    logic                        w_ovf     [1:2*LANES-1];
    logic signed [ACC_WIDTH-1:0] w_add     [1:LANES-1];
    logic                        w_add_ovf [1:LANES-1];
    logic signed [ACC_WIDTH-1:0] r_node    [1:LANES-1];
    logic                        r_ovf     [1:LANES-1];
    tag_t                        r_tag     [1:T];

    for (genvar i = 1; i < LANES; i++) begin : g_int
        assign w_node[i] = r_node[i];
        assign w_ovf[i]  = r_ovf[i];
    end
    for (genvar k = 0; k < LANES; k++) begin : g_leaf
        assign w_node[LANES+k] = i_data[k];
        assign w_ovf[LANES+k]  = 1'b0;
    end

    always_comb begin
        sat_res_t w_res;
        w_res     = '0;
        w_add     = '{default: '0};
        w_add_ovf = '{default: 1'b0};
        for (int i = 1; i < LANES; i++) begin
            w_res        = sat_add(64'(w_node[2*i]), 64'(w_node[2*i+1]), ACC_WIDTH);
            w_add[i]     = w_res.sum[ACC_WIDTH-1:0];
            w_add_ovf[i] = w_res.ovf | w_ovf[2*i] | w_ovf[2*i+1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < LANES; i++) begin
                r_node[i] <= '0;
                r_ovf[i]  <= 1'b0;
            end
            for (int s = 1; s <= T; s++) r_tag[s] <= '0;
        end else if (!i_stall) begin
            for (int i = 1; i < LANES; i++) begin
                r_node[i] <= w_add[i];
                r_ovf[i]  <= w_add_ovf[i];
            end
            r_tag[1] <= i_tag;
            for (int s = 2; s <= T; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    always_comb begin
        o_tag     = r_tag[T];
        o_tag.sat = r_tag[T].sat | r_ovf[1];
    end
    assign o_sum = r_node[1];

endmodule

// File: rtl/dot_product_pipe.sv
// Pipelined dot-product engine: X/W register storage, lane multipliers,
// saturating adder tree and a framed saturating accumulator with backpressure.
module dot_product_pipe
    import dot_product_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int LANES     = 8,
    parameter int DEPTH     = 8,
    parameter int ACC_WIDTH = 2 * WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [WIDTH-1:0]            input_data,
    input  logic [$clog2(LANES)-1:0]           addr_x,
    input  logic                               wr_en_x,
    input  logic [$clog2(LANES*DEPTH)-1:0]     addr_w,
    input  logic                               wr_en_w,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [$clog2(DEPTH)-1:0]           in_row,
    input  logic                               in_first,
    input  logic                               in_last,
    input  logic                               clear_acc,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [ACC_WIDTH-1:0]        output_data,
    output logic                               sat_flag
);
    localparam int LB = $clog2(LANES);
    localparam int AW = $clog2(LANES * DEPTH);

    logic [LANES-1:0][WIDTH-1:0]             r_x;
    logic [DEPTH-1:0][LANES-1:0][WIDTH-1:0]  r_w;
    logic [LANES-1:0][WIDTH-1:0]             w_wrow;
    logic [LANES-1:0][ACC_WIDTH-1:0]         w_prod;
    logic [LANES-1:0][ACC_WIDTH-1:0]         r_prod;
    logic [AW-LB-1:0]                        w_wr_row;
    tag_t                                    r_mtag;
    tag_t                                    w_ttag;
    logic signed [ACC_WIDTH-1:0]             w_tsum;
    logic signed [ACC_WIDTH-1:0]             r_acc;
    sat_res_t                                w_accsum;
    logic                                    r_sat;
    logic                                    r_out_valid;
    logic                                    w_stall;
    logic                                    w_sat_keep;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_wr_row = addr_w[AW-1:LB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_w <= '0;
        end else begin
            if (wr_en_x) r_x[addr_x] <= input_data;
            if (wr_en_w && (32'(w_wr_row) < DEPTH)) r_w[w_wr_row][addr_w[LB-1:0]] <= input_data;
        end
    end

    always_comb begin
        w_wrow = '0;
        if (32'(in_row) < DEPTH) w_wrow = r_w[in_row];
    end

    always_comb begin
        w_prod = '0;
        for (int l = 0; l < LANES; l++)
            w_prod[l] = ACC_WIDTH'($signed(r_x[l])) * ACC_WIDTH'($signed(w_wrow[l]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
            r_mtag <= '0;
        end else if (!w_stall) begin
            r_prod <= w_prod;
            r_mtag <= '{valid: in_valid, first: in_first, last: in_last, sat: 1'b0};
        end
    end

    sat_adder_tree #(.LANES(LANES), .ACC_WIDTH(ACC_WIDTH)) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_stall (w_stall),
        .i_tag   (r_mtag),
        .i_data  (r_prod),
        .o_tag   (w_ttag),
        .o_sum   (w_tsum)
    );

    assign w_accsum = sat_add(64'(r_acc), 64'(w_tsum), ACC_WIDTH);
    // Unstalled with out_valid high means the handshake happens this edge,
    // so the previous frame's sat history is dropped; a landing beat overrides clear_acc.
    assign w_sat_keep = r_sat && !r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            if (r_out_valid) begin
                r_out_valid <= 1'b0;
                r_sat       <= 1'b0;
            end
            if (clear_acc) begin
                r_acc <= '0;
                r_sat <= 1'b0;
            end
            if (w_ttag.valid) begin
                if (w_ttag.first) begin
                    r_acc <= w_tsum;
                    r_sat <= w_ttag.sat;
                end else begin
                    r_acc <= w_accsum.sum[ACC_WIDTH-1:0];
                    r_sat <= w_sat_keep | w_ttag.sat | w_accsum.ovf;
                end
                if (w_ttag.last) r_out_valid <= 1'b1;
            end
        end
    end

    assign output_data = r_acc;
    assign out_valid   = r_out_valid;
    assign sat_flag    = r_sat;

endmodule

// File: tb/tb_dot_product_pipe.sv
// Scoreboard bench for dot_product_pipe: a plain-arithmetic model predicts each
// framed result at issue time; a monitor checks results at the output handshake.
module tb_dot_product_pipe;
    localparam int WIDTH     = 14;
    localparam int LANES     = 8;
    localparam int DEPTH     = 8;
    localparam int ACC_WIDTH = 2 * WIDTH;
    localparam int LB = $clog2(LANES);
    localparam int AW = $clog2(LANES * DEPTH);
    localparam int RW = $clog2(DEPTH);
    localparam longint AMAX = (longint'(1) <<< (ACC_WIDTH - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACC_WIDTH - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [WIDTH-1:0] input_data = '0;
    logic [LB-1:0] addr_x = '0;
    logic wr_en_x = 1'b0;
    logic [AW-1:0] addr_w = '0;
    logic wr_en_w = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [RW-1:0] in_row = '0;
    logic in_first = 1'b0;
    logic in_last = 1'b0;
    logic clear_acc = 1'b0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [ACC_WIDTH-1:0] output_data;
    logic sat_flag;

    dot_product_pipe #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk(clk), .rst(rst), .input_data(input_data), .addr_x(addr_x), .wr_en_x(wr_en_x),
        .addr_w(addr_w), .wr_en_w(wr_en_w), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_first(in_first), .in_last(in_last), .clear_acc(clear_acc),
        .out_valid(out_valid), .out_ready(out_ready), .output_data(output_data),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint data;
        bit     sat;
        int     issue;
        bit     chk_lat;
    } exp_t;

    exp_t   sbq[$];
    longint mx[LANES];
    longint mw[DEPTH][LANES];
    longint macc = 0;
    bit     msat = 1'b0;
    bit     lat_chk = 1'b0;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint clamp(input longint s, inout bit f);
        if (s > AMAX) begin f = 1'b1; return AMAX; end
        if (s < AMIN) begin f = 1'b1; return AMIN; end
        return s;
    endfunction

    function automatic void model_reset();
        foreach (mx[i]) mx[i] = 0;
        foreach (mw[r, l]) mw[r][l] = 0;
        macc = 0;
        msat = 1'b0;
    endfunction

    // Lane products, then adjacent pairs summed with clamping, level by level.
    task automatic model_beat();
        longint v[LANES];
        bit bs = 1'b0;
        bit as = 1'b0;
        int n = LANES;
        exp_t e;
        for (int l = 0; l < LANES; l++) v[l] = mx[l] * mw[int'(in_row)][l];
        while (n > 1) begin
            for (int i = 0; i < n / 2; i++) v[i] = clamp(v[2*i] + v[2*i+1], bs);
            n = n / 2;
        end
        if (in_first) begin
            macc = v[0];
            msat = bs;
        end else begin
            macc = clamp(macc + v[0], as);
            msat = msat | bs | as;
        end
        if (in_last) begin
            e.data = macc; e.sat = msat; e.issue = cyc; e.chk_lat = lat_chk;
            sbq.push_back(e);
            msat = 1'b0;
        end
    endtask

    task automatic commit();
        if (rst) return;
        if (in_valid && in_ready) model_beat();
        if (clear_acc) begin macc = 0; msat = 1'b0; end
        if (wr_en_x) mx[int'(addr_x)] = input_data;
        if (wr_en_w && (int'(addr_w) / LANES) < DEPTH)
            mw[int'(addr_w) / LANES][int'(addr_w) % LANES] = input_data;
    endtask

    task automatic step();
        @(negedge clk);
        commit();
        @(posedge clk);
        #1;
        in_valid = 1'b0; wr_en_x = 1'b0; wr_en_w = 1'b0; clear_acc = 1'b0;
        in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic wx(input int idx, input int val);
        addr_x = LB'(idx); input_data = WIDTH'(val); wr_en_x = 1'b1; step();
    endtask

    task automatic ww(input int row, input int lane, input int val);
        addr_w = AW'(row * LANES + lane); input_data = WIDTH'(val); wr_en_w = 1'b1; step();
    endtask

    task automatic beat(input int row, input bit f, input bit l);
        in_valid = 1'b1; in_row = RW'(row); in_first = f; in_last = l; step();
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (sbq.size() != 0 && n < 100) begin step(); n++; end
        chk({name, "_drained"}, sbq.size(), 0);
    endtask

    function automatic int rv();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 16383)) - 8192;
        return int'($urandom_range(0, 40)) - 20;
    endfunction

    initial begin : monitor
        bit     pstall = 1'b0;
        longint pdata = 0;
        exp_t   e;
        forever begin
            @(negedge clk);
            if (rst) begin pstall = 1'b0; continue; end
            if (pstall) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_data", output_data, pdata);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output: got data %0d, expected no output (cycle %0d)",
                             output_data, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", output_data, e.data);
                    chk("out_sat", sat_flag, longint'(e.sat));
                    if (e.chk_lat) chk("latency", cyc - e.issue, 5);
                end
            end
            pstall = out_valid && !out_ready;
            pdata  = output_data;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_output_data", output_data, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        step();

        // X = 1..8, W row 0 = 2 -> 72 with 5-cycle latency.
        for (int i = 0; i < LANES; i++) wx(i, i + 1);
        for (int l = 0; l < LANES; l++) ww(0, l, 2);
        lat_chk = 1'b1;
        beat(0, 1'b1, 1'b1);
        lat_chk = 1'b0;
        drain("t1");

        // X = 1, rows 0/1/2 = 1/2/3 accumulated back to back -> 48.
        for (int i = 0; i < LANES; i++) wx(i, 1);
        for (int r = 0; r < 3; r++)
            for (int l = 0; l < LANES; l++) ww(r, l, r + 1);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; in_row = RW'(b); in_first = (b == 0); in_last = (b == 2);
            lat_chk = (b == 2);
            chk("t2_in_ready", in_ready, 1);
            step();
        end
        lat_chk = 1'b0;
        drain("t2");

        // Full negative range saturates every tree level.
        for (int i = 0; i < LANES; i++) wx(i, -8192);
        for (int l = 0; l < LANES; l++) ww(0, l, -8192);
        beat(0, 1'b1, 1'b1);
        drain("t3");

        // Two results stacked behind a stalled consumer.
        out_ready = 1'b0;
        beat(1, 1'b1, 1'b1);
        beat(2, 1'b1, 1'b1);
        repeat (10) step();
        drain("t4");

        // Write to X[3] collides with a beat: old value used, next beat sees new one.
        for (int i = 0; i < LANES; i++) wx(i, 0);
        for (int l = 0; l < LANES; l++) ww(1, l, 1);
        addr_x = LB'(3); input_data = WIDTH'(5); wr_en_x = 1'b1;
        in_valid = 1'b1; in_row = RW'(1); in_first = 1'b1; in_last = 1'b1;
        step();
        beat(1, 1'b1, 1'b1);
        drain("t5");

        // clear_acc on an idle pipeline drops a partial accumulation.
        beat(1, 1'b1, 1'b0);
        repeat (8) step();
        clear_acc = 1'b1;
        step();
        beat(1, 1'b0, 1'b1);
        drain("tclr");

        // Async reset with a held result and three beats in flight.
        out_ready = 1'b0;
        beat(1, 1'b1, 1'b1);
        beat(1, 1'b1, 1'b0);
        beat(1, 1'b0, 1'b0);
        beat(1, 1'b0, 1'b1);
        step();
        chk("t6_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_sat", sat_flag, 0);
        chk("t6_rst_data", output_data, 0);
        model_reset();
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();
        beat(0, 1'b1, 1'b1);
        beat(1, 1'b1, 1'b1);
        drain("t6");

        // Random loads, beats, framing and backpressure.
        for (int c = 0; c < 600; c++) begin
            out_ready  = ($urandom_range(0, 9) < 7);
            input_data = WIDTH'(rv());
            if ($urandom_range(0, 9) < 3) begin
                addr_x = LB'($urandom_range(0, LANES - 1)); wr_en_x = 1'b1;
            end
            if ($urandom_range(0, 9) < 3) begin
                addr_w = AW'($urandom_range(0, LANES * DEPTH - 1)); wr_en_w = 1'b1;
            end
            in_valid = ($urandom_range(0, 9) < 6);
            in_row   = RW'($urandom_range(0, DEPTH - 1));
            in_first = ($urandom_range(0, 3) == 0);
            in_last  = ($urandom_range(0, 9) < 3);
            step();
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
